// File: rtl/led_pwm_pkg.sv
// LED PWM bank shared definitions.
// Mode encodings, register map and CTRL bit positions.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_PWM     = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam logic [6:0] ADDR_ID    = 7'h00;
  localparam logic [6:0] ADDR_PRESC = 7'h01;
  localparam logic [6:0] ADDR_CTRL  = 7'h02;
  localparam logic [6:0] ADDR_BLINK = 7'h03;
  localparam logic [6:0] CH_BASE    = 7'h10;
  localparam int         CH_STRIDE  = 4;
  localparam logic [1:0] OFS_MODE   = 2'd0;
  localparam logic [1:0] OFS_DUTY   = 2'd1;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RESTART = 1;

  function automatic logic [6:0] ch_addr(input int n, input logic [1:0] ofs);
    return CH_BASE + 7'(CH_STRIDE * n) + 7'(ofs);
  endfunction

endpackage

// File: rtl/led_pwm_bank_if.sv
// Register bus between the SPI slave and the LED PWM bank.
// Writes are single-cycle strobes; rdat follows addr combinationally.
interface led_pwm_bank_if;
  logic        we;
  logic [6:0]  addr;
  logic [31:0] wdat;
  logic [31:0] rdat;

  modport master (output we, addr, wdat, input rdat);
  modport slave  (input we, addr, wdat, output rdat);
endinterface

// File: rtl/led_pwm_chan.sv
// One LED channel: mode, duty shadow/active, breathe ramp
// and the registered PWM output.
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             frame_end_i,
  input  logic             blink_ph_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic             mode_we_i,
  input  logic             duty_we_i,
  input  logic [PWM_W-1:0] wdat_i,
  output mode_e            mode_o,
  output logic [PWM_W-1:0] duty_o,
  output logic             pwm_o
);

  mode_e            mode_q, mode_d;
  logic [PWM_W-1:0] shad_q, shad_d;
  logic [PWM_W-1:0] act_q, act_d;
  logic [PWM_W-1:0] ramp_q, ramp_d;
  logic [PWM_W-1:0] cmp;
  logic             dn_q, dn_d;
  logic             out_q, out_d;

  always_comb begin
    mode_d = mode_we_i ? mode_e'(wdat_i[1:0]) : mode_q;
    shad_d = duty_we_i ? wdat_i : shad_q;
    // shad_d already carries a same-cycle write into the frame load
    act_d  = frame_end_i ? shad_d : act_q;
    ramp_d = ramp_q;
    dn_d   = dn_q;
    if (!en_i || restart_i ||
        (mode_we_i && mode_d == MODE_BREATHE)) begin
      ramp_d = '0;
      dn_d   = 1'b0;
    end else if (frame_end_i) begin
      if (!dn_q) begin
        if (ramp_q < act_q) ramp_d = ramp_q + 1'b1;
        else                dn_d   = 1'b1;
      end else begin
        if (ramp_q != '0) ramp_d = ramp_q - 1'b1;
        else              dn_d   = 1'b0;
      end
    end
    cmp   = (mode_q == MODE_BREATHE) ? ramp_q : act_q;
    out_d = en_i && (mode_q != MODE_OFF) &&
            (pwm_cnt_i < cmp) &&
            ((mode_q != MODE_BLINK) || blink_ph_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_OFF;
      shad_q <= '0;
      act_q  <= '0;
      ramp_q <= '0;
      dn_q   <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      shad_q <= shad_d;
      act_q  <= act_d;
      ramp_q <= ramp_d;
      dn_q   <= dn_d;
      out_q  <= out_d;
    end
  end

  assign mode_o = mode_q;
  assign duty_o = shad_q;
  assign pwm_o  = out_q;

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM/blink/breathe controller with a shared
// prescaler, frame counter and blink phase.
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int          NCH       = 3,
  parameter int          PWM_W     = 8,
  parameter int          PRESC_W   = 16,
  parameter int          PRESC_DEF = 46,
  parameter int          BLINK_DEF = 23,
  parameter logic [31:0] BASE_ID   = 32'h1CE50200
) (
  input  logic               clk,
  input  logic               reset,
  led_pwm_bank_if.slave      bus,
  output logic [NCH-1:0]     pwm_o,
  output logic               frame_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [15:0]        blink_q, blink_d;
  logic [15:0]        bcnt_q, bcnt_d;
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               ph_q, ph_d;
  logic               frame_q;
  logic               wr_presc, wr_ctrl, wr_blink;
  logic               restart, tick, frame_end;
  logic               unused_wdat;

  assign wr_presc  = bus.we && (bus.addr == ADDR_PRESC);
  assign wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);
  assign wr_blink  = bus.we && (bus.addr == ADDR_BLINK);
  assign restart   = wr_ctrl && bus.wdat[CTRL_RESTART];
  assign tick      = en_q && (pcnt_q == '0);
  assign frame_end = tick && (cnt_q == '1);
  assign unused_wdat = ^bus.wdat;

  always_comb begin
    presc_d = wr_presc ? bus.wdat[PRESC_W-1:0] : presc_q;
    blink_d = wr_blink ? bus.wdat[15:0] : blink_q;
    en_d    = wr_ctrl ? bus.wdat[CTRL_EN] : en_q;
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    ph_d    = ph_q;
    if (!en_q || restart) begin
      pcnt_d = '0;
      cnt_d  = '0;
      bcnt_d = '0;
      ph_d   = 1'b0;
    end else begin
      if (tick) begin
        pcnt_d = presc_q;
        cnt_d  = cnt_q + 1'b1;
      end else begin
        pcnt_d = pcnt_q - 1'b1;
      end
      if (frame_end) begin
        if (bcnt_q == blink_q) begin
          bcnt_d = '0;
          ph_d   = ~ph_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= PRESC_W'(PRESC_DEF);
      blink_q <= 16'(BLINK_DEF);
      en_q    <= 1'b0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      ph_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      blink_q <= blink_d;
      en_q    <= en_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      ph_q    <= ph_d;
      frame_q <= frame_end;
    end
  end

  assign frame_o = frame_q;

  mode_e            ch_mode [NCH];
  logic [PWM_W-1:0] ch_duty [NCH];
  logic [NCH-1:0]   mode_we, duty_we;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    assign mode_we[n] = bus.we && (bus.addr == ch_addr(n, OFS_MODE));
    assign duty_we[n] = bus.we && (bus.addr == ch_addr(n, OFS_DUTY));

    led_pwm_chan #(.PWM_W(PWM_W)) u_chan (
      .clk         (clk),
      .reset       (reset),
      .en_i        (en_q),
      .restart_i   (restart),
      .frame_end_i (frame_end),
      .blink_ph_i  (ph_q),
      .pwm_cnt_i   (cnt_q),
      .mode_we_i   (mode_we[n]),
      .duty_we_i   (duty_we[n]),
      .wdat_i      (bus.wdat[PWM_W-1:0]),
      .mode_o      (ch_mode[n]),
      .duty_o      (ch_duty[n]),
      .pwm_o       (pwm_o[n])
    );
  end

  always_comb begin
    bus.rdat = '0;
    case (bus.addr)
      ADDR_ID:    bus.rdat = BASE_ID;
      ADDR_PRESC: bus.rdat = 32'(presc_q);
      ADDR_CTRL:  bus.rdat = {31'b0, en_q};
      ADDR_BLINK: bus.rdat = {16'b0, blink_q};
      default:    ;
    endcase
    for (int n = 0; n < NCH; n++) begin
      if (bus.addr == ch_addr(n, OFS_MODE)) bus.rdat = {30'b0, ch_mode[n]};
      if (bus.addr == ch_addr(n, OFS_DUTY)) bus.rdat = 32'(ch_duty[n]);
    end
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Scoreboard bench for led_pwm_bank: per-frame high counts,
// frame period, register readback and reset behaviour.
module tb_led_pwm_bank;
  import led_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] pwm_o;
  logic       frame_o;
  logic       rd_req = 1'b0;

  led_pwm_bank_if bus ();

  led_pwm_bank #(.NCH(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .pwm_o   (pwm_o),
    .frame_o (frame_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          tag;
    logic [31:0] exp;
  } rd_t;

  typedef struct {
    int idx;
    int h0;
    int h1;
    int h2;
    int per;
  } fr_t;

  rd_t rq[$];
  fr_t fq[$];
  rd_t re;
  fr_t fe;

  int checks = 0;
  int failures = 0;
  int fcnt = 0;
  int per = 0;
  int acc[3];

  // expected high clocks per frame, index = frame number
  int t0[27] = '{0, 0, 64, 64, 192, 192, 32, 32, 32, 32, 32,
                 32, 32, 32, 32, 32, 32, 32, 32, 32, 32,
                 32, 0, 32, 32, 0, 10};
  int t1[27] = '{0, 0, 0, 255, 255, 0, 0, 255, 255, 0, 0,
                 255, 255, 0, 0, 255, 255, 0, 0, 255, 255,
                 0, 0, 0, 255, 0, 0};
  int t2[27] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3,
                 4, 4, 3, 2, 1, 0, 0, 1, 2, 1,
                 2, 0, 1, 2, 0, 0};

  task automatic cmp(input string nm, input int idx,
                     input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) acc[c] = 0;
      per = 0;
    end else begin
      for (int c = 0; c < 3; c++) acc[c] += int'(pwm_o[c]);
      per++;
      if (frame_o) begin
        fcnt++;
        if (fq.size() > 0 && fq[0].idx == fcnt) begin
          fe = fq.pop_front();
          cmp("frame_ch0", fe.idx, acc[0], fe.h0);
          cmp("frame_ch1", fe.idx, acc[1], fe.h1);
          cmp("frame_ch2", fe.idx, acc[2], fe.h2);
          if (fe.per != 0) cmp("frame_period", fe.idx, per, fe.per);
        end
        for (int c = 0; c < 3; c++) acc[c] = 0;
        per = 0;
      end
    end
    if (rd_req) begin
      if (rq.size() == 0) begin
        cmp("rq_empty", 0, 1, 0);
      end else begin
        re = rq.pop_front();
        case (re.kind)
          0:       cmp("rdat", re.tag, bus.rdat, re.exp);
          1:       cmp("pwm_o", re.tag, pwm_o, re.exp);
          default: cmp("frame_count", re.tag, fcnt, re.exp);
        endcase
      end
    end
  end

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdat = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic chk(input int kind, input logic [6:0] a, input logic [31:0] e);
    rd_t r;
    r.kind = kind;
    r.tag = int'(a);
    r.exp = e;
    rq.push_back(r);
    bus.addr = a;
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic push_frames(input int lo, input int hi);
    fr_t f;
    for (int i = lo; i <= hi; i++) begin
      if (i == 22) continue;
      f.idx = i;
      f.h0 = t0[i];
      f.h1 = t1[i];
      f.h2 = t2[i];
      f.per = (i == 1 || i == 25) ? 0 : 256;
      fq.push_back(f);
    end
  endtask

  task automatic wait_frame(input int n);
    int t;
    t = 0;
    while (fcnt < n && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (fcnt < n) begin
      checks++;
      failures++;
      $display("FAIL wait_frame[%0d] got=%0d exp=%0d", n, fcnt, n);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdat = '0;
    skip(3);
    reset = 1'b0;

    chk(0, ADDR_ID, 32'h1CE50200);
    chk(0, ADDR_PRESC, 46);
    chk(0, ADDR_BLINK, 23);
    chk(0, 7'h10, 0);
    chk(0, ADDR_CTRL, 0);
    chk(0, 7'h05, 0);
    skip(300);
    chk(1, 0, 0);
    chk(2, 0, 0);

    wr(ADDR_PRESC, 32'hABCD0000);
    wr(ADDR_BLINK, 32'h00010001);
    wr(7'h11, 32'h140);
    wr(7'h10, 1);
    wr(7'h15, 255);
    wr(7'h14, 32'h6);
    wr(7'h19, 4);
    chk(0, ADDR_PRESC, 0);
    chk(0, ADDR_BLINK, 1);
    chk(0, 7'h11, 64);
    chk(0, 7'h14, 2);
    chk(0, 7'h19, 4);
    chk(0, 7'h12, 0);

    push_frames(1, 21);
    wr(ADDR_CTRL, 1);

    wait_frame(2);
    skip(98);
    wr(7'h11, 192);

    wait_frame(4);
    skip(254);
    wr(7'h11, 32);

    wait_frame(6);
    skip(98);
    wr(7'h18, 3);

    wait_frame(18);
    skip(98);
    wr(7'h18, 3);

    wait_frame(21);
    skip(98);
    push_frames(23, 24);
    wr(ADDR_CTRL, 3);
    chk(0, ADDR_CTRL, 1);

    wait_frame(24);
    skip(48);
    chk(1, 0, 3'b010);
    #2;
    reset = 1'b1;
    chk(1, 0, 0);
    skip(2);
    reset = 1'b0;

    chk(0, ADDR_PRESC, 46);
    chk(0, ADDR_BLINK, 23);
    chk(0, ADDR_CTRL, 0);
    chk(0, 7'h10, 0);
    chk(0, 7'h11, 0);
    chk(0, 7'h18, 0);
    skip(300);
    chk(2, 0, 24);
    chk(1, 0, 0);

    wr(ADDR_PRESC, 0);
    wr(7'h11, 10);
    wr(7'h10, 1);
    push_frames(25, 26);
    wr(ADDR_CTRL, 1);
    wait_frame(26);
    skip(4);

    cmp("pending_frames", 0, fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
